// File: rtl/hamming_rx_sequencer.sv
// Frames the UART bit stream into 7-bit codewords for the Hamming decoder and
// pairs the decoded nibbles into bytes delivered through a 2-entry FIFO.
module hamming_rx_sequencer #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flush,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       dec_ena,
  output logic       dec_bit,
  input  logic       dec_valid,
  input  logic [3:0] dec_nibble,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  input  logic       err_clr,
  output logic       err_drop,
  output logic       err_tmo,
  output logic       err_ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_bcnt;
  logic       r_nsel;
  logic [3:0] r_low;
  logic [3:0] r_wcnt;
  logic [7:0] r_fifo0;
  logic [7:0] r_fifo1;
  logic [1:0] r_count;
  logic       r_dec_ena;
  logic       r_dec_bit;
  logic       r_err_drop;
  logic       r_err_tmo;
  logic       r_err_ovf;

  logic       w_accept;
  logic       w_capture;
  logic       w_timeout;
  logic       w_drop;
  logic       w_push;
  logic       w_pop;
  logic       w_push_ok;
  logic       w_ovf;
  logic [7:0] w_push_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // en=0 outranks flush, which outranks normal sequencing
  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = S_IDLE;
    end else if (flush) begin
      w_state_next = S_SHIFT;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_SHIFT;
        S_SHIFT: if (bit_valid && (r_bcnt == 3'd6)) w_state_next = S_WAIT;
        S_WAIT:  if (dec_valid || w_timeout) w_state_next = S_SHIFT;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_drop    = 1'b0;
    if (en && !flush) begin
      case (r_state)
        S_SHIFT: w_accept = bit_valid;
        S_WAIT: begin
          w_capture = dec_valid;
          w_timeout = !dec_valid && (r_wcnt == 4'(TIMEOUT - 1));
          w_drop    = bit_valid;
        end
        default: ;
      endcase
    end
  end

  assign w_push      = w_capture && r_nsel;
  assign w_push_byte = {dec_nibble, r_low};
  assign w_pop       = (r_count != 2'd0) && out_ready;
  assign w_push_ok   = w_push && ((r_count != 2'd2) || w_pop);
  assign w_ovf       = w_push && !w_push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_ena <= 1'b0;
      r_dec_bit <= 1'b0;
      r_bcnt    <= 3'd0;
      r_nsel    <= 1'b0;
      r_low     <= 4'd0;
      r_wcnt    <= 4'd0;
    end else begin
      r_dec_ena <= w_accept;
      if (w_accept) r_dec_bit <= bit_in;
      if (!en || flush || (r_state == S_IDLE)) begin
        r_bcnt <= 3'd0;
        r_nsel <= 1'b0;
        r_wcnt <= 4'd0;
      end else begin
        if (w_accept) r_bcnt <= (r_bcnt == 3'd6) ? 3'd0 : r_bcnt + 3'd1;
        if (r_state == S_SHIFT) r_wcnt <= 4'd0;
        if ((r_state == S_WAIT) && !dec_valid) r_wcnt <= r_wcnt + 4'd1;
        if (w_capture) begin
          if (!r_nsel) r_low <= dec_nibble;
          r_nsel <= !r_nsel;
        end
        // a timeout abandons any half-built byte
        if (w_timeout) r_nsel <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo0 <= 8'd0;
      r_fifo1 <= 8'd0;
      r_count <= 2'd0;
    end else if (w_pop && w_push_ok) begin
      if (r_count == 2'd1) begin
        r_fifo0 <= w_push_byte;
      end else begin
        r_fifo0 <= r_fifo1;
        r_fifo1 <= w_push_byte;
      end
    end else if (w_pop) begin
      r_fifo0 <= r_fifo1;
      r_count <= r_count - 2'd1;
    end else if (w_push_ok) begin
      if (r_count == 2'd0) r_fifo0 <= w_push_byte;
      else r_fifo1 <= w_push_byte;
      r_count <= r_count + 2'd1;
    end
  end

  // a new error event beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_drop <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      if (w_drop) r_err_drop <= 1'b1;
      else if (err_clr) r_err_drop <= 1'b0;
      if (w_timeout) r_err_tmo <= 1'b1;
      else if (err_clr) r_err_tmo <= 1'b0;
      if (w_ovf) r_err_ovf <= 1'b1;
      else if (err_clr) r_err_ovf <= 1'b0;
    end
  end

  assign dec_ena   = r_dec_ena;
  assign dec_bit   = r_dec_bit;
  assign out_valid = (r_count != 2'd0);
  assign out_byte  = r_fifo0;
  assign err_drop  = r_err_drop;
  assign err_tmo   = r_err_tmo;
  assign err_ovf   = r_err_ovf;

endmodule
